// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame shape and the baud
// divisor helper used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Round up so the line is never faster than the requested baud rate.
    function automatic int calc_clk_per_bit(input int clk_rate, input int baud_rate);
        return (clk_rate + baud_rate - 1) / baud_rate;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with occupancy count; depth must be a power of two
// so the pointers wrap without extra logic.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] pop_data,
    output logic                 full,
    output logic                 empty,
    output logic [AW:0]          count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW:0]          count_r;
    logic                 full_s;
    logic                 empty_s;
    logic                 push_ok_s;
    logic                 pop_ok_s;

    assign full_s    = (count_r == DEPTH_C);
    assign empty_s   = (count_r == {(AW+1){1'b0}});
    assign push_ok_s = push && !full_s;
    assign pop_ok_s  = pop && !empty_s;

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_r;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are sent LSB first,
// back-to-back with no idle gap while data is waiting and block is low.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_RATE         = 50000000,
    parameter int SERIAL_BAUD_RATE = 500000,
    parameter int CLK_PER_BIT      = calc_clk_per_bit(CLK_RATE, SERIAL_BAUD_RATE),
    parameter int FIFO_DEPTH       = 16,
    parameter int FIFO_AW          = $clog2(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    input  logic               block,
    output logic               full,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow,
    output logic               tx,
    output logic               busy
);

    localparam int                 CNT_W    = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0]   BIT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [2:0]         IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_e            state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [2:0]           idx_r;
    logic [7:0]           shift_r;
    logic                 tx_r;
    logic                 overflow_r;
    logic                 bit_end_s;
    logic                 start_ok_s;
    logic                 pop_s;
    logic [7:0]           pop_data_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [FIFO_AW:0]     fifo_count_s;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop_s),
        .pop_data  (pop_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign bit_end_s  = (cnt_r == BIT_LAST);
    assign start_ok_s = !fifo_empty_s && !block;

    // A new frame may only be launched from IDLE or on the final STOP cycle.
    always_comb begin
        pop_s = 1'b0;
        if (start_ok_s && (state_r == IDLE)) begin
            pop_s = 1'b1;
        end else if (start_ok_s && (state_r == STOP) && bit_end_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Dropped writes are judged against full as it stood before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= wr_en && fifo_full_s;
        end
    end

    // Transmit FSM with registered line output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (pop_s) begin
                        shift_r <= pop_data_s;
                        state_r <= START;
                        tx_r    <= 1'b0;
                    end else begin
                        tx_r    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        idx_r   <= 3'd0;
                        state_r <= DATA;
                        tx_r    <= shift_r[0];
                    end else begin
                        cnt_r   <= cnt_r + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (idx_r == IDX_LAST) begin
                            state_r <= STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            idx_r   <= idx_r + 3'd1;
                            shift_r <= {1'b0, shift_r[7:1]};
                            tx_r    <= shift_r[1];
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (pop_s) begin
                            shift_r <= pop_data_s;
                            state_r <= START;
                            tx_r    <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign tx         = tx_r;
    assign overflow   = overflow_r;
    assign full       = fifo_full_s;
    assign fifo_count = fifo_count_s;
    assign busy       = (state_r != IDLE) || !fifo_empty_s;

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Buffered 8N1 UART transmitter that returns status and readback bytes from the PGM8755 to the host PC. It is the transmit counterpart to the host-command receive path. Logic writes bytes into an internal FIFO at any rate. The block serializes them LSB-first, back-to-back, at SERIAL_BAUD_RATE. The FIFO lets bursts (e.g. an EPROM page readback) be queued without waiting on the line.

Parameters:
CLK_RATE, 50000000, system clock frequency in Hz
SERIAL_BAUD_RATE, 500000, line bit rate in baud
CLK_PER_BIT, ceil(CLK_RATE/SERIAL_BAUD_RATE) = 100, clock cycles per serial bit; legal range is 2 or more
FIFO_DEPTH, 16, byte FIFO depth; must be a power of two, 2 or more
FIFO_AW, log2(FIFO_DEPTH) = 4, FIFO address width

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  asynchronous, active-low reset
wr_en  input  1  push wr_data into the FIFO this cycle
wr_data  input  8  byte to queue
block  input  1  while high, no new frame starts; a frame in flight always completes
full  output  1  FIFO holds FIFO_DEPTH bytes
fifo_count  output  FIFO_AW+1  bytes currently queued, excluding the frame in flight
overflow  output  1  one-cycle pulse when a write is dropped
tx  output  1  serial line; idles high
busy  output  1  high when a frame is in flight or fifo_count != 0

Behaviour:
- Reset (rst low, asynchronous):
  - tx=1, busy=0, full=0, fifo_count=0, overflow=0.
  - FIFO pointers cleared; FSM forced to IDLE.
  - Reset mid-frame truncates the frame; tx returns high immediately.
- FIFO writes:
  - A write is accepted when wr_en=1 and full=0; count increments after that edge.
  - wr_en=1 with full=1: the byte is dropped and overflow pulses high for the next cycle.
  - This applies even if a pop occurs on the same edge; full is judged before the edge.
  - A simultaneous accepted write and pop leaves fifo_count unchanged.
- Pops:
  - A pop happens only when fifo_count != 0 before the edge. There is no empty-FIFO bypass.
- FSM states: IDLE, START, DATA, STOP. A bit counter counts 0..CLK_PER_BIT-1 and a bit index counts 0..7.
  - IDLE: tx=1. If fifo_count != 0 and block=0: pop into the shift register, go to START with tx=0.
  - START: hold tx=0 for CLK_PER_BIT cycles, then go to DATA with index=0 and tx=shift[0].
  - DATA: each bit is held CLK_PER_BIT cycles, LSB first. After bit 7, go to STOP with tx=1.
  - STOP: hold tx=1 for CLK_PER_BIT cycles. At the last STOP cycle, if fifo_count != 0 and block=0, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Timing:
  - A write accepted at edge k into an empty FIFO with the FSM in IDLE makes tx fall after edge k+1.
  - Every bit lasts exactly CLK_PER_BIT cycles.
  - A frame is exactly 10*CLK_PER_BIT cycles; back-to-back frames have a period of exactly 10*CLK_PER_BIT.
- Outputs:
  - tx is registered, with no glitches.
  - busy and full are derived from registered state.
- block:
  - Sampled only in IDLE and at the last STOP cycle.
  - Asserting block mid-frame has no effect on the current frame.
- Pointers wrap modulo FIFO_DEPTH. fifo_count saturates structurally at FIFO_DEPTH; it can never exceed it.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE/START/DATA/STOP)
  - DATA_BITS=8
  - STOP_BITS=1
  - CLK_PER_BIT computation helper shared with the receive side
- Sub-module byte_fifo: synchronous single-clock FIFO, parameterized on depth, with push/pop/full/empty/count.
- The FSM and shift register stay in uart_tx_buffered.

Test Plan:
All scenarios use CLK_PER_BIT=100.
- Reset, then single byte: write 0xA5 → after 1 cycle tx reads 0,1,0,1,0,0,1,0,1,1, each level 100 cycles; busy falls exactly 1000 cycles after tx falls.
- Burst: write 0x00, 0xFF, 0x55 on three consecutive cycles → fifo_count peaks at 2; three frames are contiguous with no high gap between the stop bit and the next start bit; total 3000 cycles.
- Overflow: with block=1, write 17 bytes 0x00..0x10 → full=1 after the 16th write, the 17th is dropped, overflow pulses once, fifo_count=16; release block → 16 frames carrying 0x00..0x0F.
- Simultaneous write and pop when full: at the last STOP cycle with count=16, assert wr_en → write dropped, overflow=1, count=15 next cycle.
- Block mid-frame: assert block during DATA bit 3 of 0x3C with 0x81 queued → 0x3C completes, tx stays high, 0x81 starts 1 cycle after block deasserts.
- Reset mid-frame: pull rst low during bit 5 → tx=1 and busy=0 immediately; after release, a new write of 0x12 transmits correctly.
